burst_cycle_counter: RTL and testbench

Parametrised successor to the free-running cycle counter. It counts a programmable number of "slow" cycles, each made of `count_max+1` enabled clocks, then stops (single-shot) or restarts (continuous). It provides per-cycle and per-run strobes, and latches its settings at run boundaries so software can reprogram it without glitches. It sits between the AXI config registers and the acquisition/averaging datapath, and gates frame and accumulate boundaries.

---
 rtl/wrap_counter.sv | 37 +++
 rtl/burst_cycle_counter.sv | 137 +++++++++++++
 tb/tb_burst_cycle_counter.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wrap_counter.sv
// Up-counter that rolls back to zero after reaching max; wrap marks the
// enabled clock on which that rollover happens.
module wrap_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);

  logic [WIDTH-1:0] r_count;

  assign wrap  = en && (r_count == max);
  assign count = r_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= ZERO;
    end else if (clr) begin
      r_count <= ZERO;
    end else if (wrap) begin
      r_count <= ZERO;
    end else if (en) begin
      r_count <= r_count + ONE;
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/burst_cycle_counter.sv
// Counts runs of n_cycles slow cycles of (count_max+1) enabled clocks each,
// single-shot or continuous, with settings latched only at run boundaries.
module burst_cycle_counter #(
  parameter int FAST_COUNT_WIDTH = 10,
  parameter int SLOW_COUNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        sclr,
  input  logic                        clken,
  input  logic                        start,
  input  logic                        continuous,
  input  logic [FAST_COUNT_WIDTH-1:0] count_max,
  input  logic [SLOW_COUNT_WIDTH-1:0] n_cycles,
  output logic [FAST_COUNT_WIDTH-1:0] fast_count,
  output logic [SLOW_COUNT_WIDTH-1:0] slow_count,
  output logic                        end_cycle,
  output logic                        end_run,
  output logic                        busy
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [SLOW_COUNT_WIDTH-1:0] SLOW_ONE  = SLOW_COUNT_WIDTH'(1);
  localparam logic [SLOW_COUNT_WIDTH-1:0] SLOW_ZERO = SLOW_COUNT_WIDTH'(0);
  localparam logic [FAST_COUNT_WIDTH-1:0] FAST_ZERO = FAST_COUNT_WIDTH'(0);

  logic                        r_state;
  logic                        w_next_state;
  logic [FAST_COUNT_WIDTH-1:0] r_cm_q;
  logic [SLOW_COUNT_WIDTH-1:0] r_nc_q;
  logic [SLOW_COUNT_WIDTH-1:0] w_slow_max;
  logic                        r_end_cycle;
  logic                        r_end_run;
  logic                        w_fast_en;
  logic                        w_fast_wrap;
  logic                        w_slow_wrap;
  logic                        w_load;

  // nc_q == 0 underflows to all ones, giving the full 2^SLOW_COUNT_WIDTH cycles
  assign w_slow_max = r_nc_q - SLOW_ONE;

  wrap_counter #(.WIDTH(FAST_COUNT_WIDTH)) u_fast (
    .clk    (clk),
    .resetn (resetn),
    .clr    (sclr),
    .en     (w_fast_en),
    .max    (r_cm_q),
    .count  (fast_count),
    .wrap   (w_fast_wrap)
  );

  wrap_counter #(.WIDTH(SLOW_COUNT_WIDTH)) u_slow (
    .clk    (clk),
    .resetn (resetn),
    .clr    (sclr),
    .en     (w_fast_wrap),
    .max    (w_slow_max),
    .count  (slow_count),
    .wrap   (w_slow_wrap)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else if (sclr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_RUN;
        else       w_next_state = ST_IDLE;
      end
      ST_RUN: begin
        if (w_slow_wrap && !continuous) w_next_state = ST_IDLE;
        else                            w_next_state = ST_RUN;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Shadows reload on a start from IDLE or on a continuous run boundary
  always_comb begin
    w_fast_en = 1'b0;
    w_load    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_fast_en = 1'b0;
        w_load    = start;
      end
      ST_RUN: begin
        w_fast_en = clken;
        w_load    = w_slow_wrap && continuous;
      end
      default: begin
        w_fast_en = 1'b0;
        w_load    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cm_q      <= FAST_ZERO;
      r_nc_q      <= SLOW_ZERO;
      r_end_cycle <= 1'b0;
      r_end_run   <= 1'b0;
    end else if (sclr) begin
      r_cm_q      <= FAST_ZERO;
      r_nc_q      <= SLOW_ZERO;
      r_end_cycle <= 1'b0;
      r_end_run   <= 1'b0;
    end else begin
      if (w_load) begin
        r_cm_q <= count_max;
        r_nc_q <= n_cycles;
      end else begin
        r_cm_q <= r_cm_q;
        r_nc_q <= r_nc_q;
      end
      r_end_cycle <= w_fast_wrap;
      r_end_run   <= w_slow_wrap;
    end
  end

  assign end_cycle = r_end_cycle;
  assign end_run   = r_end_run;
  assign busy      = (r_state == ST_RUN);

endmodule

// File: tb/tb_burst_cycle_counter.sv
// Scoreboarded bench for burst_cycle_counter: tasks queue the cycle numbers at
// which pulses must appear, a negedge monitor pops and compares them.
module tb_burst_cycle_counter;

  localparam int FW  = 10;
  localparam int SW  = 16;
  localparam int SW4 = 4;

  logic          clk        = 1'b0;
  logic          resetn     = 1'b1;
  logic          sclr       = 1'b0;
  logic          clken      = 1'b1;
  logic          start      = 1'b0;
  logic          continuous = 1'b0;
  logic [FW-1:0] count_max  = 10'd0;
  logic [SW-1:0] n_cycles   = 16'd0;
  logic [FW-1:0] fast_count;
  logic [SW-1:0] slow_count;
  logic          end_cycle, end_run, busy;

  logic           start4 = 1'b0;
  logic [FW-1:0]  cm4    = 10'd0;
  logic [SW4-1:0] nc4    = 4'd0;
  logic [FW-1:0]  fast4;
  logic [SW4-1:0] slow4;
  logic           ec4, er4, busy4;

  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   exp_c;
  logic mon_en = 1'b0;
  int   q_ec[$];
  int   q_er[$];
  int   q4_ec[$];
  int   q4_er[$];

  burst_cycle_counter #(.FAST_COUNT_WIDTH(FW), .SLOW_COUNT_WIDTH(SW)) u_dut (
    .clk(clk), .resetn(resetn), .sclr(sclr), .clken(clken), .start(start),
    .continuous(continuous), .count_max(count_max), .n_cycles(n_cycles),
    .fast_count(fast_count), .slow_count(slow_count), .end_cycle(end_cycle),
    .end_run(end_run), .busy(busy)
  );

  burst_cycle_counter #(.FAST_COUNT_WIDTH(FW), .SLOW_COUNT_WIDTH(SW4)) u_dut4 (
    .clk(clk), .resetn(resetn), .sclr(1'b0), .clken(1'b1), .start(start4),
    .continuous(1'b0), .count_max(cm4), .n_cycles(nc4),
    .fast_count(fast4), .slow_count(slow4), .end_cycle(ec4),
    .end_run(er4), .busy(busy4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every observed pulse must match the head of its queue
  always @(negedge clk) begin
    if (mon_en) begin
      if (end_cycle) begin
        n_chk++;
        if (q_ec.size() == 0) $display("FAIL end_cycle: unexpected pulse at cycle %0d", cyc);
        else begin
          exp_c = q_ec.pop_front();
          if (exp_c != cyc) $display("FAIL end_cycle: pulse at cycle %0d, required %0d", cyc, exp_c);
          else n_pass++;
        end
      end
      if (end_run) begin
        n_chk++;
        if (q_er.size() == 0) $display("FAIL end_run: unexpected pulse at cycle %0d", cyc);
        else begin
          exp_c = q_er.pop_front();
          if (exp_c != cyc) $display("FAIL end_run: pulse at cycle %0d, required %0d", cyc, exp_c);
          else n_pass++;
        end
      end
      if (ec4) begin
        n_chk++;
        if (q4_ec.size() == 0) $display("FAIL end_cycle4: unexpected pulse at cycle %0d", cyc);
        else begin
          exp_c = q4_ec.pop_front();
          if (exp_c != cyc) $display("FAIL end_cycle4: pulse at cycle %0d, required %0d", cyc, exp_c);
          else n_pass++;
        end
      end
      if (er4) begin
        n_chk++;
        if (q4_er.size() == 0) $display("FAIL end_run4: unexpected pulse at cycle %0d", cyc);
        else begin
          exp_c = q4_er.pop_front();
          if (exp_c != cyc) $display("FAIL end_run4: pulse at cycle %0d, required %0d", cyc, exp_c);
          else n_pass++;
        end
      end
    end
  end

  task automatic test_reset();
    #1 resetn = 1'b0;
    #2;
    n_chk++;
    if ({busy, end_cycle, end_run} !== 3'b000 || fast_count !== 10'd0 || slow_count !== 16'd0)
      $display("FAIL reset_outputs: busy=%b ec=%b er=%b fast=%0d slow=%0d, required all 0",
               busy, end_cycle, end_run, fast_count, slow_count);
    else n_pass++;
    n_chk++;
    if ({busy4, ec4, er4} !== 3'b000 || fast4 !== 10'd0 || slow4 !== 4'd0)
      $display("FAIL reset_outputs4: busy=%b ec=%b er=%b fast=%0d slow=%0d, required all 0",
               busy4, ec4, er4, fast4, slow4);
    else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) $display("FAIL idle_after_reset: busy=%b, required 0", busy);
    else n_pass++;
  endtask

  task automatic test_single_shot();
    int e;
    @(negedge clk);
    count_max = 10'd15; n_cycles = 16'd4; continuous = 1'b0; clken = 1'b1; start = 1'b1;
    e = cyc + 1;
    for (int i = 1; i <= 4; i++) q_ec.push_back(e + 16 * i);
    q_er.push_back(e + 64);
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || fast_count !== 10'd0) $display("FAIL ss_busy_rise: busy=%b fast=%0d, required 1/0", busy, fast_count);
    else n_pass++;
    while (cyc < e + 20) @(negedge clk);
    n_chk++;
    if (fast_count !== 10'd4 || slow_count !== 16'd1)
      $display("FAIL ss_midrun: fast=%0d slow=%0d, required 4/1", fast_count, slow_count);
    else n_pass++;
    while (cyc < e + 63) @(negedge clk);
    n_chk++;
    if (busy !== 1'b1 || fast_count !== 10'd15 || slow_count !== 16'd3)
      $display("FAIL ss_last_clock: busy=%b fast=%0d slow=%0d, required 1/15/3", busy, fast_count, slow_count);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || fast_count !== 10'd0 || slow_count !== 16'd0)
      $display("FAIL ss_end: busy=%b fast=%0d slow=%0d, required 0/0/0", busy, fast_count, slow_count);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_chk++;
    if (q_ec.size() != 0 || q_er.size() != 0)
      $display("FAIL ss_pending: %0d end_cycle and %0d end_run pulses missing, required 0", q_ec.size(), q_er.size());
    else n_pass++;
  endtask

  task automatic test_continuous();
    int e;
    @(negedge clk);
    count_max = 10'd15; n_cycles = 16'd2; continuous = 1'b1; start = 1'b1;
    e = cyc + 1;
    q_ec.push_back(e + 16); q_ec.push_back(e + 32); q_ec.push_back(e + 40);
    q_ec.push_back(e + 48); q_ec.push_back(e + 56); q_ec.push_back(e + 64);
    q_er.push_back(e + 32); q_er.push_back(e + 48); q_er.push_back(e + 64);
    @(negedge clk);
    start = 1'b0;
    count_max = 10'd7;
    while (cyc < e + 32) @(negedge clk);
    n_chk++;
    if (busy !== 1'b1 || fast_count !== 10'd0 || slow_count !== 16'd0)
      $display("FAIL cont_boundary: busy=%b fast=%0d slow=%0d, required 1/0/0", busy, fast_count, slow_count);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (fast_count !== 10'd1) $display("FAIL cont_no_gap: fast=%0d, required 1", fast_count);
    else n_pass++;
    while (cyc < e + 50) @(negedge clk);
    continuous = 1'b0;
    while (cyc < e + 64) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) $display("FAIL cont_stop: busy=%b, required 0", busy);
    else n_pass++;
    repeat (6) @(negedge clk);
    n_chk++;
    if (q_ec.size() != 0 || q_er.size() != 0)
      $display("FAIL cont_pending: %0d end_cycle and %0d end_run pulses missing, required 0", q_ec.size(), q_er.size());
    else n_pass++;
  endtask

  task automatic test_clken_toggle();
    int e;
    @(negedge clk);
    count_max = 10'd3; n_cycles = 16'd1; continuous = 1'b1; start = 1'b1; clken = 1'b0;
    e = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      q_ec.push_back(e + 7 + 8 * i);
      q_er.push_back(e + 7 + 8 * i);
    end
    while (cyc < e + 24) begin
      @(negedge clk);
      start = 1'b0;
      clken = ((cyc + 1 - e) % 2 == 1);
      if (cyc == e + 16) continuous = 1'b0;
      if (cyc == e + 4) begin
        n_chk++;
        if (fast_count !== 10'd2) $display("FAIL clken_freeze: fast=%0d, required 2", fast_count);
        else n_pass++;
      end
    end
    clken = 1'b1;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL clken_stop: busy=%b, required 0", busy);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_chk++;
    if (q_ec.size() != 0 || q_er.size() != 0)
      $display("FAIL clken_pending: %0d end_cycle and %0d end_run pulses missing, required 0", q_ec.size(), q_er.size());
    else n_pass++;
  endtask

  task automatic test_count_max_zero();
    int e;
    @(negedge clk);
    cm4 = 10'd0; nc4 = 4'd0; start4 = 1'b1;
    e = cyc + 1;
    for (int i = 1; i <= 16; i++) q4_ec.push_back(e + i);
    q4_er.push_back(e + 16);
    @(negedge clk);
    start4 = 1'b0;
    while (cyc < e + 15) @(negedge clk);
    n_chk++;
    if (slow4 !== 4'd15 || busy4 !== 1'b1) $display("FAIL cm0_slow15: slow=%0d busy=%b, required 15/1", slow4, busy4);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (slow4 !== 4'd0 || busy4 !== 1'b0) $display("FAIL cm0_wrap: slow=%0d busy=%b, required 0/0", slow4, busy4);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++;
    if (q4_ec.size() != 0 || q4_er.size() != 0)
      $display("FAIL cm0_pending: %0d end_cycle and %0d end_run pulses missing, required 0", q4_ec.size(), q4_er.size());
    else n_pass++;
  endtask

  task automatic test_sclr();
    int e;
    @(negedge clk);
    count_max = 10'd15; n_cycles = 16'd4; continuous = 1'b0; start = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < e + 5) @(negedge clk);
    n_chk++;
    if (fast_count !== 10'd5) $display("FAIL sclr_setup: fast=%0d, required 5", fast_count);
    else n_pass++;
    sclr = 1'b1; start = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({busy, end_cycle, end_run} !== 3'b000 || fast_count !== 10'd0 || slow_count !== 16'd0)
      $display("FAIL sclr_clear: busy=%b ec=%b er=%b fast=%0d slow=%0d, required all 0",
               busy, end_cycle, end_run, fast_count, slow_count);
    else n_pass++;
    sclr = 1'b0; start = 1'b0;
    repeat (70) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || fast_count !== 10'd0) $display("FAIL sclr_idle: busy=%b fast=%0d, required 0/0", busy, fast_count);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int e;
    @(negedge clk);
    count_max = 10'd15; n_cycles = 16'd4; continuous = 1'b0; start = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < e + 5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    n_chk++;
    if ({busy, end_cycle, end_run} !== 3'b000 || fast_count !== 10'd0 || slow_count !== 16'd0)
      $display("FAIL areset_clear: busy=%b ec=%b er=%b fast=%0d slow=%0d, required all 0",
               busy, end_cycle, end_run, fast_count, slow_count);
    else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || fast_count !== 10'd0) $display("FAIL areset_idle: busy=%b fast=%0d, required 0/0", busy, fast_count);
    else n_pass++;
    count_max = 10'd1; n_cycles = 16'd2; start = 1'b1;
    e = cyc + 1;
    q_ec.push_back(e + 2); q_ec.push_back(e + 4); q_er.push_back(e + 4);
    @(negedge clk);
    start = 1'b0;
    while (cyc < e + 4) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) $display("FAIL areset_restart_end: busy=%b, required 0", busy);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++;
    if (q_ec.size() != 0 || q_er.size() != 0)
      $display("FAIL areset_pending: %0d end_cycle and %0d end_run pulses missing, required 0", q_ec.size(), q_er.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int e;
    @(negedge clk);
    count_max = 10'd1; n_cycles = 16'd1; continuous = 1'b0; start = 1'b1;
    e = cyc + 1;
    q_ec.push_back(e + 2); q_er.push_back(e + 2);
    q_ec.push_back(e + 6); q_er.push_back(e + 6);
    @(negedge clk);
    count_max = 10'd2;
    while (cyc < e + 2) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) $display("FAIL b2b_idle_gap: busy=%b, required 0", busy);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b1) $display("FAIL b2b_restart: busy=%b, required 1", busy);
    else n_pass++;
    start = 1'b0;
    while (cyc < e + 5) @(negedge clk);
    n_chk++;
    if (fast_count !== 10'd2) $display("FAIL b2b_new_shadow: fast=%0d, required 2", fast_count);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) $display("FAIL b2b_end: busy=%b, required 0", busy);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++;
    if (q_ec.size() != 0 || q_er.size() != 0)
      $display("FAIL b2b_pending: %0d end_cycle and %0d end_run pulses missing, required 0", q_ec.size(), q_er.size());
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_shot();
    test_continuous();
    test_clken_toggle();
    test_count_max_zero();
    test_sclr();
    test_async_reset();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
